// File: rtl/wb_pipe_pkg.sv
// Shared configuration for the writeback stage.
//   DEFAULT_XLEN : default datapath width
//   LD_B/H/W/D   : encodings of the load size field (byte/half/word/double)
package wb_pipe_pkg;

  localparam int DEFAULT_XLEN = 64;

  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;
  localparam logic [1:0] LD_D = 2'd3;

endpackage

// File: rtl/wb_pipe_load_ext.sv
// Load data alignment and extension (purely combinational).
//   raw    : doubleword read data from the memory stage
//   off    : byte offset of the load inside the doubleword
//   size   : LD_B / LD_H / LD_W / LD_D
//   uns    : 1 = zero-extend, 0 = sign-extend
//   result : aligned, extended XLEN-bit load value
module load_ext
  import wb_pipe_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      off,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;

  // Byte offset becomes a bit shift of off*8.
  assign shifted = raw >> {off, 3'b000};

  // The mask keeps the loaded bits; the bits outside the mask are filled
  // with the sign bit when sign extension is requested. With XLEN=32 the
  // word mask is already all ones, so LD_W and LD_D behave identically.
  always_comb begin
    mask = '1;
    sign = 1'b0;
    case (size)
      LD_B: begin
        mask = XLEN'(8'hFF);
        sign = shifted[7];
      end
      LD_H: begin
        mask = XLEN'(16'hFFFF);
        sign = shifted[15];
      end
      LD_W: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        mask = '1;
        sign = 1'b0;
      end
    endcase
    result = shifted & mask;
    if (!uns && sign) begin
      result = result | ~mask;
    end
  end

endmodule

// File: rtl/wb_pipe.sv
// Writeback stage: one-entry stage register between the memory stage and
// the register files.
//   clk, rst              : clock, synchronous active-high reset
//   in_*                  : retiring instruction from the memory stage
//   in_valid / in_ready   : upstream handshake
//   flush                 : drop the entry presented this cycle
//   hold                  : freeze the staged entry (debug/halt)
//   rf_*                  : GPR write port
//   csr_*                 : CSR write port
//   commit_valid/pc       : instruction retires this cycle
//   fwd_*                 : forwarding of the staged result to earlier stages
//   retire_cnt            : 64-bit retired instruction count (wraps)
module wb_pipe
  import wb_pipe_pkg::*;
#(
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int NSRC    = 3,
  parameter int MEM_SRC = 1,
  parameter int RA_W    = 5,
  parameter int CA_W    = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NSRC)-1:0]  in_src_sel,
  input  logic [NSRC*XLEN-1:0]     in_src_data,
  input  logic [1:0]               in_ld_size,
  input  logic                     in_ld_unsigned,
  input  logic [2:0]               in_ld_off,
  input  logic [RA_W-1:0]          in_rd,
  input  logic                     in_rd_we,
  input  logic                     in_csr_we,
  input  logic [CA_W-1:0]          in_csr_addr,
  input  logic [XLEN-1:0]          in_csr_wdata,
  input  logic [XLEN-1:0]          in_pc,
  input  logic                     flush,
  input  logic                     hold,
  output logic                     rf_we,
  output logic [RA_W-1:0]          rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic                     csr_we,
  output logic [CA_W-1:0]          csr_waddr,
  output logic [XLEN-1:0]          csr_wdata,
  output logic                     commit_valid,
  output logic [XLEN-1:0]          commit_pc,
  output logic                     fwd_valid,
  output logic [RA_W-1:0]          fwd_rd,
  output logic [XLEN-1:0]          fwd_data,
  output logic [63:0]              retire_cnt
);

  // Handshake: a transfer happens on a rising edge where in_valid and
  // in_ready are both high. in_ready never depends on in_valid or flush, and
  // the upstream must hold its entry stable until the transfer. A transfer
  // made while flush is high is consumed and discarded.

  logic            valid_q;
  logic [XLEN-1:0] result_q;
  logic [RA_W-1:0] rd_q;
  logic            rd_we_q;
  logic            csr_we_q;
  logic [CA_W-1:0] csr_addr_q;
  logic [XLEN-1:0] csr_wdata_q;
  logic [XLEN-1:0] pc_q;
  logic [63:0]     retire_cnt_q;

  logic            rtr;
  logic            accept;
  logic [XLEN-1:0] src_val;
  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] result_d;

  assign rtr      = valid_q && !hold;
  assign in_ready = !valid_q || !hold;
  assign accept   = in_valid && in_ready && !flush;

  // Source select; an out-of-range index falls through to zero.
  always_comb begin
    src_val = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (int'(in_src_sel) == i) begin
        src_val = in_src_data[i*XLEN +: XLEN];
      end
    end
  end

  load_ext #(
    .XLEN(XLEN)
  ) u_load_ext (
    .raw   (in_src_data[MEM_SRC*XLEN +: XLEN]),
    .off   (in_ld_off),
    .size  (in_ld_size),
    .uns   (in_ld_unsigned),
    .result(ld_val)
  );

  assign result_d = (int'(in_src_sel) == MEM_SRC) ? ld_val : src_val;

  // Stage register. With hold high and an entry staged, in_ready is low so
  // nothing is accepted and rtr is low, leaving the entry untouched. With
  // hold high and the stage empty the stage still accepts, since it has
  // advertised in_ready to the upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      result_q     <= '0;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      csr_we_q     <= 1'b0;
      csr_addr_q   <= '0;
      csr_wdata_q  <= '0;
      pc_q         <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (accept) begin
        valid_q     <= 1'b1;
        result_q    <= result_d;
        rd_q        <= in_rd;
        rd_we_q     <= in_rd_we;
        csr_we_q    <= in_csr_we;
        csr_addr_q  <= in_csr_addr;
        csr_wdata_q <= in_csr_wdata;
        pc_q        <= in_pc;
      end else if (rtr) begin
        valid_q <= 1'b0;
      end
      if (rtr) begin
        retire_cnt_q <= retire_cnt_q + 64'd1;
      end
    end
  end

  // x0 is never written, but the instruction still commits.
  assign rf_we        = rtr && rd_we_q && (rd_q != '0);
  assign rf_waddr     = rd_q;
  assign rf_wdata     = result_q;
  assign csr_we       = rtr && csr_we_q;
  assign csr_waddr    = csr_addr_q;
  assign csr_wdata    = csr_wdata_q;
  assign commit_valid = rtr;
  assign commit_pc    = pc_q;

  // Forwarding stays visible while held: the result is final once staged.
  assign fwd_valid  = valid_q && rd_we_q && (rd_q != '0);
  assign fwd_rd     = rd_q;
  assign fwd_data   = result_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_pipe.sv
// Self-checking bench for wb_pipe (XLEN=64, NSRC=3, MEM_SRC=1).
module tb_wb_pipe;

  localparam logic [63:0] RAW = 64'h8877_6655_4433_2211;

  typedef struct {
    logic [63:0] pc;
    logic        rf_we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
  } exp_t;

  typedef struct {
    logic [1:0]  sel;
    logic [63:0] src;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  off;
    logic [4:0]  rd;
    logic        rd_we;
    logic        csr_we;
    logic [11:0] caddr;
    logic [63:0] cdata;
    logic [63:0] exp_data;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_src_sel;
  logic [191:0] in_src_data;
  logic [1:0]   in_ld_size;
  logic         in_ld_unsigned;
  logic [2:0]   in_ld_off;
  logic [4:0]   in_rd;
  logic         in_rd_we;
  logic         in_csr_we;
  logic [11:0]  in_csr_addr;
  logic [63:0]  in_csr_wdata;
  logic [63:0]  in_pc;
  logic         flush;
  logic         hold;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [63:0]  rf_wdata;
  logic         csr_we;
  logic [11:0]  csr_waddr;
  logic [63:0]  csr_wdata;
  logic         commit_valid;
  logic [63:0]  commit_pc;
  logic         fwd_valid;
  logic [4:0]   fwd_rd;
  logic [63:0]  fwd_data;
  logic [63:0]  retire_cnt;

  wb_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_src_sel(in_src_sel), .in_src_data(in_src_data),
    .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
    .in_ld_off(in_ld_off), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_csr_we(in_csr_we), .in_csr_addr(in_csr_addr),
    .in_csr_wdata(in_csr_wdata), .in_pc(in_pc), .flush(flush), .hold(hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt)
  );

  // scoreboard state
  exp_t        exp_q[$];
  exp_t        cur_exp;
  logic        m_valid = 1'b0;
  logic [63:0] exp_cnt = '0;
  logic [63:0] pc_ctr = 64'h1000;
  int          n_cmp = 0;
  int          n_err = 0;
  int          rf_we_pulses = 0;
  bit          chk_en = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(input logic [1:0] sel, input logic [63:0] src,
                              input logic [1:0] size, input logic uns,
                              input logic [2:0] off, input logic [4:0] rd,
                              input logic rd_we, input logic cwe,
                              input logic [11:0] caddr, input logic [63:0] cdata,
                              input logic [63:0] exp_data);
    vec_t v;
    v.sel = sel; v.src = src; v.size = size; v.uns = uns; v.off = off;
    v.rd = rd; v.rd_we = rd_we; v.csr_we = cwe; v.caddr = caddr;
    v.cdata = cdata; v.exp_data = exp_data;
    return v;
  endfunction

  // driver: advance the model for the edge just taken, then apply inputs
  task automatic drive(input vec_t v, input bit vld, input bit fl,
                       input bit hd, input bit r);
    logic [63:0] s[3];
    bit acc;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      exp_cnt = '0;
      exp_q.delete();
    end else begin
      acc = in_valid && (!m_valid || !hold) && !flush;
      if (m_valid && !hold) exp_cnt++;
      if (acc) exp_q.push_back(cur_exp);
      if (acc) m_valid = 1'b1;
      else if (!hold) m_valid = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) s[i] = {$urandom, $urandom};
    if (v.sel < 2'd3) s[v.sel] = v.src;
    pc_ctr = pc_ctr + 64'd4;
    rst = r; in_valid = vld; flush = fl; hold = hd;
    in_src_sel = v.sel; in_src_data = {s[2], s[1], s[0]};
    in_ld_size = v.size; in_ld_unsigned = v.uns; in_ld_off = v.off;
    in_rd = v.rd; in_rd_we = v.rd_we; in_csr_we = v.csr_we;
    in_csr_addr = v.caddr; in_csr_wdata = v.cdata; in_pc = pc_ctr;
    cur_exp.pc = pc_ctr;
    cur_exp.rf_we = v.rd_we && (v.rd != 5'd0);
    cur_exp.rd = v.rd;
    cur_exp.data = v.exp_data;
    cur_exp.csr_we = v.csr_we;
    cur_exp.csr_addr = v.caddr;
    cur_exp.csr_wdata = v.cdata;
  endtask

  task automatic idle(input bit hd, input bit r);
    vec_t z;
    z = mk(2'd0, 64'd0, 2'd0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 12'd0, 64'd0, 64'd0);
    drive(z, 1'b0, 1'b0, hd, r);
  endtask

  // monitor: compares every cycle against the model, pops on commit
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      chk("in_ready", 64'(in_ready), 64'(!m_valid || !hold));
      chk("commit_valid", 64'(commit_valid), 64'(m_valid && !hold));
      chk("retire_cnt", retire_cnt, exp_cnt);
      if (m_valid && exp_q.size() > 0) begin
        chk("fwd_valid", 64'(fwd_valid), 64'(exp_q[0].rf_we));
        if (exp_q[0].rf_we) begin
          chk("fwd_rd", 64'(fwd_rd), 64'(exp_q[0].rd));
          chk("fwd_data", fwd_data, exp_q[0].data);
        end
      end else begin
        chk("fwd_valid_idle", 64'(fwd_valid), 64'd0);
      end
      if (rf_we) rf_we_pulses++;
      if (commit_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_commit: pc %h with nothing expected", commit_pc);
        end else begin
          e = exp_q.pop_front();
          chk("commit_pc", commit_pc, e.pc);
          chk("rf_we", 64'(rf_we), 64'(e.rf_we));
          if (e.rf_we) chk("rf_waddr", 64'(rf_waddr), 64'(e.rd));
          chk("rf_wdata", rf_wdata, e.data);
          chk("csr_we", 64'(csr_we), 64'(e.csr_we));
          if (e.csr_we) begin
            chk("csr_waddr", 64'(csr_waddr), 64'(e.csr_addr));
            chk("csr_wdata", csr_wdata, e.csr_wdata);
          end
        end
      end else begin
        chk("rf_we_idle", 64'(rf_we), 64'd0);
        chk("csr_we_idle", 64'(csr_we), 64'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t tbl[13];
  vec_t v;
  int   p0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; hold = 1'b0;
    in_src_sel = '0; in_src_data = '0; in_ld_size = '0; in_ld_unsigned = 1'b0;
    in_ld_off = '0; in_rd = '0; in_rd_we = 1'b0; in_csr_we = 1'b0;
    in_csr_addr = '0; in_csr_wdata = '0; in_pc = '0;
    cur_exp = '{default: '0};

    //             sel  src                    size uns off rd  we cwe caddr    cdata  expected
    tbl[0]  = mk(2'd0, 64'hDEAD,               2'd0, 0, 3'd0, 5, 1, 0, 12'h0,   64'h0, 64'hDEAD);
    tbl[1]  = mk(2'd2, 64'h1234_5678_9ABC_DEF0, 2'd0, 0, 3'd0, 6, 1, 0, 12'h0,  64'h0, 64'h1234_5678_9ABC_DEF0);
    tbl[2]  = mk(2'd1, RAW, 2'd0, 0, 3'd7, 8,  1, 0, 12'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FF88);
    tbl[3]  = mk(2'd1, RAW, 2'd1, 1, 3'd4, 9,  1, 0, 12'h0, 64'h0, 64'h0000_0000_0000_6655);
    tbl[4]  = mk(2'd1, RAW, 2'd2, 0, 3'd4, 10, 1, 0, 12'h0, 64'h0, 64'hFFFF_FFFF_8877_6655);
    tbl[5]  = mk(2'd1, RAW, 2'd3, 0, 3'd0, 11, 1, 0, 12'h0, 64'h0, RAW);
    tbl[6]  = mk(2'd1, RAW, 2'd0, 1, 3'd0, 12, 1, 0, 12'h0, 64'h0, 64'h11);
    tbl[7]  = mk(2'd1, RAW, 2'd1, 0, 3'd6, 13, 1, 0, 12'h0, 64'h0, 64'hFFFF_FFFF_FFFF_8877);
    tbl[8]  = mk(2'd1, RAW, 2'd2, 1, 3'd0, 14, 1, 0, 12'h0, 64'h0, 64'h4433_2211);
    tbl[9]  = mk(2'd3, 64'h0, 2'd0, 0, 3'd0, 15, 1, 0, 12'h0, 64'h0, 64'h0);
    tbl[10] = mk(2'd0, 64'h55, 2'd0, 0, 3'd0, 0, 1, 0, 12'h0, 64'h0, 64'h55);
    tbl[11] = mk(2'd0, 64'h66, 2'd0, 0, 3'd0, 3, 0, 1, 12'h300, 64'h8, 64'h66);
    tbl[12] = mk(2'd1, RAW, 2'd0, 0, 3'd1, 16, 1, 0, 12'h0, 64'h0, 64'h22);

    // reset
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("reset_rf_wdata", rf_wdata, 64'd0);
    chk("reset_csr_waddr", 64'(csr_waddr), 64'd0);
    chk("reset_csr_wdata", csr_wdata, 64'd0);
    chk("reset_commit_pc", commit_pc, 64'd0);
    chk("reset_fwd_data", fwd_data, 64'd0);
    chk("reset_retire_cnt", retire_cnt, 64'd0);

    // back-to-back ALU stream
    p0 = rf_we_pulses;
    for (int i = 0; i < 4; i++) begin
      v = mk(2'd0, 64'h10 + 64'(i), 2'd0, 0, 3'd0, 5'(i + 1), 1, 0, 12'h0,
             64'h0, 64'h10 + 64'(i));
      drive(v, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    @(negedge clk);
    chk("stream_rf_we_pulses", 64'(rf_we_pulses - p0), 64'd4);
    chk("stream_retire_cnt", retire_cnt, 64'd4);

    // table vectors, back to back
    for (int i = 0; i < 13; i++) drive(tbl[i], 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // hold for 3 cycles with an entry staged, new entry waiting upstream
    v = mk(2'd0, 64'h77, 2'd0, 0, 3'd0, 5'd7, 1, 0, 12'h0, 64'h0, 64'h77);
    drive(v, 1'b1, 1'b0, 1'b0, 1'b0);
    p0 = rf_we_pulses;
    v = mk(2'd0, 64'h78, 2'd0, 0, 3'd0, 5'd8, 1, 0, 12'h0, 64'h0, 64'h78);
    for (int i = 0; i < 3; i++) begin
      drive(v, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_rf_we", 64'(rf_we), 64'd0);
      chk("hold_fwd_valid", 64'(fwd_valid), 64'd1);
      chk("hold_fwd_rd", 64'(fwd_rd), 64'd7);
    end
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    @(negedge clk);
    chk("hold_release_pulses", 64'(rf_we_pulses - p0), 64'd1);

    // flush with in_valid: staged entry retires, flushed one never does
    v = mk(2'd0, 64'hA0, 2'd0, 0, 3'd0, 5'd20, 1, 0, 12'h0, 64'h0, 64'hA0);
    drive(v, 1'b1, 1'b0, 1'b0, 1'b0);
    v = mk(2'd0, 64'hB0, 2'd0, 0, 3'd0, 5'd21, 1, 0, 12'h0, 64'h0, 64'hB0);
    drive(v, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_staged_retires", 64'(commit_valid), 64'd1);
    idle(1'b0, 1'b0);
    @(negedge clk);
    chk("flush_dropped", 64'(commit_valid), 64'd0);

    // flush and hold together
    v = mk(2'd0, 64'hC0, 2'd0, 0, 3'd0, 5'd22, 1, 0, 12'h0, 64'h0, 64'hC0);
    drive(v, 1'b1, 1'b0, 1'b0, 1'b0);
    v = mk(2'd0, 64'hD0, 2'd0, 0, 3'd0, 5'd23, 1, 0, 12'h0, 64'h0, 64'hD0);
    drive(v, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_hold_commit", 64'(commit_valid), 64'd0);
    idle(1'b0, 1'b0);
    @(negedge clk);
    chk("flush_hold_release", 64'(commit_valid), 64'd1);
    idle(1'b0, 1'b0);
    @(negedge clk);
    chk("flush_hold_dropped", 64'(commit_valid), 64'd0);

    // counter wrap
    v = mk(2'd0, 64'hE0, 2'd0, 0, 3'd0, 5'd24, 1, 0, 12'h0, 64'h0, 64'hE0);
    drive(v, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    idle(1'b0, 1'b0);
    @(negedge clk);
    chk("wrap_retire_cnt", retire_cnt, 64'd0);

    // reset in the middle of a stream
    v = mk(2'd0, 64'hF0, 2'd0, 0, 3'd0, 5'd25, 1, 0, 12'h0, 64'h0, 64'hF0);
    drive(v, 1'b1, 1'b0, 1'b0, 1'b0);
    v = mk(2'd0, 64'hF1, 2'd0, 0, 3'd0, 5'd26, 1, 0, 12'h0, 64'h0, 64'hF1);
    drive(v, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1'b0, 1'b0);
    @(negedge clk);
    chk("midreset_commit", 64'(commit_valid), 64'd0);
    chk("midreset_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("midreset_retire_cnt", retire_cnt, 64'd0);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      v = mk(2'd0, {$urandom, $urandom}, 2'd0, 0, 3'd0,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
             {$urandom, $urandom}, 64'd0);
      v.exp_data = v.src;
      drive(v, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) == 0), 1'b0);
    end
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    @(negedge clk);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
